// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master pipelined Wishbone arbiter.
package wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_A = 2'd1,
        ARB_OWN_B = 2'd2
    } arb_state_t;

    localparam int WB_PEND_W = 5;
    localparam int WB_TMO_W  = 10;

    localparam logic [WB_PEND_W-1:0] WB_PEND_MAX = '1;

endpackage

// File: rtl/wb_pipe_arbiter_if.sv
// Bus bundle around the arbiter: master A (data), master B (prefetch) and the shared global bus.
// 'slave' is the arbiter's view; 'master' is the view of whatever drives the masters and the bus slave.
interface wb_pipe_arbiter_if #(
    parameter int AW = 32
);
    logic          i_a_cyc, i_a_stb, i_a_we;
    logic [AW-1:0] i_a_addr;
    logic [31:0]   i_a_data;
    logic          o_a_ack, o_a_stall, o_a_err;

    logic          i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0] i_b_addr;
    logic [31:0]   i_b_data;
    logic          o_b_ack, o_b_stall, o_b_err;

    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic          i_wb_ack, i_wb_stall, i_wb_err;

    modport slave (
        input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        output o_a_ack, o_a_stall, o_a_err,
        input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        output o_b_ack, o_b_stall, o_b_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_ack, i_wb_stall, i_wb_err
    );

    modport master (
        output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        input  o_a_ack, o_a_stall, o_a_err,
        output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        input  o_b_ack, o_b_stall, o_b_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_ack, i_wb_stall, i_wb_err
    );

endinterface

// File: rtl/wb_arb_timeout.sv
// Response watchdog: down-counter reloaded whenever nothing is outstanding or a response arrives;
// o_expire pulses on the clock the count reaches zero with a request still unanswered.
module wb_arb_timeout
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pend_nz,
    input  logic i_resp,
    output logic o_expire
);

    localparam logic [WB_TMO_W-1:0] TC_LOAD = WB_TMO_W'(TIMEOUT - 1);

    logic [WB_TMO_W-1:0] cnt;
    logic                run;

    assign run      = i_pend_nz & ~i_resp;
    assign o_expire = run & (cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= TC_LOAD;
        end else if (!run) begin
            cnt <= TC_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/wb_pipe_arbiter.sv
// Two-master pipelined Wishbone arbiter: A = memory-unit data path, B = instruction prefetch.
// Define WBARB_TIMEOUT_EN to add the missing-ACK watchdog (forced error after TIMEOUT clocks).
//
// state     | meaning
// ARB_IDLE  | no owner, both masters stalled, shared bus idle
// ARB_OWN_A | master A owns the shared bus until it drops CYC
// ARB_OWN_B | master B owns the shared bus until it drops CYC
module wb_pipe_arbiter
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int PRIO_A  = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    wb_pipe_arbiter_if.slave bus
);

    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("wb_pipe_arbiter: TIMEOUT must be in 1..1023");
    end

    arb_state_t           state, state_nxt;
    logic                 last_b;
    logic [WB_PEND_W-1:0] pend, pend_nxt;
    logic                 expire;
    logic                 lock_a, lock_b;
    logic                 req_a, req_b;

    logic                 fwd_cyc, fwd_stb, fwd_we;
    logic [AW-1:0]        fwd_addr;
    logic [31:0]          fwd_data;
    logic                 own_a, own_b;
    logic                 accept, resp;

`ifdef WBARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pend_nz (pend != '0),
        .i_resp    (resp),
        .o_expire  (expire)
    );

    // A timed-out master is locked out until it finally drops CYC, so it cannot be re-granted mid-cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_a <= 1'b0;
            lock_b <= 1'b0;
        end else begin
            lock_a <= bus.i_a_cyc & (lock_a | (expire & (state == ARB_OWN_A)));
            lock_b <= bus.i_b_cyc & (lock_b | (expire & (state == ARB_OWN_B)));
        end
    end
`else
    assign expire = 1'b0;
    assign lock_a = 1'b0;
    assign lock_b = 1'b0;
`endif

    assign req_a  = bus.i_a_cyc & ~lock_a;
    assign req_b  = bus.i_b_cyc & ~lock_b;
    assign resp   = bus.i_wb_ack | bus.i_wb_err;
    assign accept = fwd_stb & ~bus.i_wb_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (req_a && req_b) begin
                    state_nxt = ((PRIO_A != 0) || last_b) ? ARB_OWN_A : ARB_OWN_B;
                end else if (req_a) begin
                    state_nxt = ARB_OWN_A;
                end else if (req_b) begin
                    state_nxt = ARB_OWN_B;
                end
            end
            ARB_OWN_A: if (!bus.i_a_cyc || expire) state_nxt = ARB_IDLE;
            ARB_OWN_B: if (!bus.i_b_cyc || expire) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        own_a    = (state == ARB_OWN_A);
        own_b    = (state == ARB_OWN_B);
        fwd_cyc  = 1'b0;
        fwd_stb  = 1'b0;
        fwd_we   = 1'b0;
        fwd_addr = '0;
        fwd_data = '0;
        if (own_a) begin
            fwd_cyc  = bus.i_a_cyc;
            fwd_stb  = bus.i_a_stb & bus.i_a_cyc;
            fwd_we   = bus.i_a_we;
            fwd_addr = bus.i_a_addr;
            fwd_data = bus.i_a_data;
        end else if (own_b) begin
            fwd_cyc  = bus.i_b_cyc;
            fwd_stb  = bus.i_b_stb & bus.i_b_cyc;
            fwd_we   = bus.i_b_we;
            fwd_addr = bus.i_b_addr;
            fwd_data = bus.i_b_data;
        end
        if (expire) begin
            fwd_cyc = 1'b0;
            fwd_stb = 1'b0;
        end
    end

    assign bus.o_wb_cyc  = fwd_cyc;
    assign bus.o_wb_stb  = fwd_stb;
    assign bus.o_wb_we   = fwd_we;
    assign bus.o_wb_addr = fwd_addr;
    assign bus.o_wb_data = fwd_data;

    assign bus.o_a_stall = ~own_a | bus.i_wb_stall;
    assign bus.o_b_stall = ~own_b | bus.i_wb_stall;
    assign bus.o_a_ack   = own_a & bus.i_wb_ack;
    assign bus.o_b_ack   = own_b & bus.i_wb_ack;
    assign bus.o_a_err   = own_a & (bus.i_wb_err | expire);
    assign bus.o_b_err   = own_b & (bus.i_wb_err | expire);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_b <= 1'b1;
        end else if ((state == ARB_IDLE) && (state_nxt != ARB_IDLE)) begin
            last_b <= (state_nxt == ARB_OWN_B);
        end
    end

    // Outstanding-request count; a new owner or any error abandons whatever was in flight.
    always_comb begin
        pend_nxt = pend;
        if ((state_nxt != state) || bus.i_wb_err || expire) begin
            pend_nxt = '0;
        end else if (accept && !resp) begin
            if (pend != WB_PEND_MAX) pend_nxt = pend + WB_PEND_W'(1);
        end else if (resp && !accept) begin
            if (pend != '0) pend_nxt = pend - WB_PEND_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_wb_pipe_arbiter.sv
// Self-checking bench for wb_pipe_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_wb_pipe_arbiter;
    import wb_pkg::*;

    localparam int AW     = 32;
    localparam int TMO    = 8;
    localparam int PRIO_A = 1;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    wb_pipe_arbiter_if #(.AW(AW)) bus_if ();

    wb_pipe_arbiter #(
        .AW      (AW),
        .PRIO_A  (PRIO_A),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_if)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model: owner 0=none 1=A 2=B
    int m_own, m_pend, m_wait;
    bit m_last_b, m_lock_a, m_lock_b;

    // packed outputs: [72]cyc [71]stb [70]we [69:38]addr [37:6]data [5]a_ack [4]a_stall [3]a_err [2]b_ack [1]b_stall [0]b_err
    function automatic logic [72:0] dut_outputs();
        return {bus_if.o_wb_cyc, bus_if.o_wb_stb, bus_if.o_wb_we, bus_if.o_wb_addr, bus_if.o_wb_data,
                bus_if.o_a_ack, bus_if.o_a_stall, bus_if.o_a_err, bus_if.o_b_ack, bus_if.o_b_stall, bus_if.o_b_err};
    endfunction

    function automatic bit m_expire();
`ifdef WBARB_TIMEOUT_EN
        return (m_pend != 0) && !(bus_if.i_wb_ack || bus_if.i_wb_err) && (m_wait == TMO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [72:0] m_outputs();
        logic c, s, w;
        logic [31:0] ad, dt;
        bit ex;
        ex = m_expire();
        c = 0; s = 0; w = 0; ad = '0; dt = '0;
        if (m_own == 1) begin
            c = bus_if.i_a_cyc; s = bus_if.i_a_cyc & bus_if.i_a_stb; w = bus_if.i_a_we;
            ad = bus_if.i_a_addr; dt = bus_if.i_a_data;
        end else if (m_own == 2) begin
            c = bus_if.i_b_cyc; s = bus_if.i_b_cyc & bus_if.i_b_stb; w = bus_if.i_b_we;
            ad = bus_if.i_b_addr; dt = bus_if.i_b_data;
        end
        if (ex) begin c = 0; s = 0; end
        return {c, s, w, ad, dt,
                (m_own == 1) && bus_if.i_wb_ack, (m_own != 1) || bus_if.i_wb_stall, (m_own == 1) && (bus_if.i_wb_err || ex),
                (m_own == 2) && bus_if.i_wb_ack, (m_own != 2) || bus_if.i_wb_stall, (m_own == 2) && (bus_if.i_wb_err || ex)};
    endfunction

    task automatic model_reset();
        m_own = 0; m_pend = 0; m_wait = 0;
        m_last_b = 1'b1; m_lock_a = 1'b0; m_lock_b = 1'b0;
    endtask

    task automatic model_update();
        logic [72:0] o;
        bit ex, resp, acc, ra, rb, ocyc;
        int nown, np;
        o    = m_outputs();
        ex   = m_expire();
        resp = bus_if.i_wb_ack | bus_if.i_wb_err;
        acc  = o[71] & ~bus_if.i_wb_stall;
        nown = m_own;
        if (m_own == 0) begin
            ra = bus_if.i_a_cyc && !m_lock_a;
            rb = bus_if.i_b_cyc && !m_lock_b;
            if (ra && rb) nown = (PRIO_A != 0 || m_last_b) ? 1 : 2;
            else if (ra) nown = 1;
            else if (rb) nown = 2;
        end else begin
            ocyc = (m_own == 1) ? bus_if.i_a_cyc : bus_if.i_b_cyc;
            if (!ocyc || ex) nown = 0;
        end
        if (nown != m_own || bus_if.i_wb_err || ex) np = 0;
        else begin
            np = m_pend + int'(acc) - int'(resp);
            if (np > 31) np = 31;
            if (np < 0) np = 0;
        end
        m_wait   = (m_pend != 0 && !resp && !ex) ? m_wait + 1 : 0;
        m_lock_a = bus_if.i_a_cyc && (m_lock_a || (ex && m_own == 1));
        m_lock_b = bus_if.i_b_cyc && (m_lock_b || (ex && m_own == 2));
        if (m_own == 0 && nown != 0) m_last_b = (nown == 2);
        m_own  = nown;
        m_pend = np;
    endtask

    task automatic step();
        @(posedge i_clk);
        if (i_rst_n) model_update();
        else model_reset();
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.i_a_cyc = 0; bus_if.i_a_stb = 0; bus_if.i_a_we = 0; bus_if.i_a_addr = '0; bus_if.i_a_data = '0;
        bus_if.i_b_cyc = 0; bus_if.i_b_stb = 0; bus_if.i_b_we = 0; bus_if.i_b_addr = '0; bus_if.i_b_data = '0;
        bus_if.i_wb_ack = 0; bus_if.i_wb_stall = 0; bus_if.i_wb_err = 0;
    endtask

    task automatic test_reset();
        logic [72:0] exp_o;
        exp_o = '0; exp_o[4] = 1'b1; exp_o[1] = 1'b1;
        idle_inputs();
        i_rst_n = 1'b0;
        model_reset();
        step(); step();
        if (dut_outputs() !== exp_o) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected %h", dut_outputs(), exp_o);
        end
        n_vec++;
        if (dut.state !== ARB_IDLE || dut.pend !== 5'd0) begin
            n_bad++; $display("FAIL reset_state: state %0d pend %0d, expected IDLE and 0", dut.state, dut.pend);
        end
        n_vec++;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        bus_if.i_a_cyc = 1; bus_if.i_a_stb = 1; bus_if.i_a_we = 0; bus_if.i_a_addr = 32'h100;
        @(negedge i_clk);
        if (bus_if.o_wb_cyc !== 1'b0 || bus_if.o_a_stall !== 1'b1) begin
            n_bad++; $display("FAIL read_pre_grant: cyc %b a_stall %b, expected 0 1", bus_if.o_wb_cyc, bus_if.o_a_stall);
        end
        n_vec++;
        step();
        @(negedge i_clk);
        if (bus_if.o_wb_cyc !== 1'b1 || bus_if.o_wb_stb !== 1'b1 || bus_if.o_wb_addr !== 32'h100 || bus_if.o_a_stall !== 1'b0) begin
            n_bad++; $display("FAIL read_granted: cyc %b stb %b addr %h a_stall %b, expected 1 1 100 0",
                              bus_if.o_wb_cyc, bus_if.o_wb_stb, bus_if.o_wb_addr, bus_if.o_a_stall);
        end
        n_vec++;
        step();
        bus_if.i_a_stb = 0; bus_if.i_wb_ack = 1;
        @(negedge i_clk);
        if (bus_if.o_a_ack !== 1'b1 || bus_if.o_b_ack !== 1'b0) begin
            n_bad++; $display("FAIL read_ack_route: a_ack %b b_ack %b, expected 1 0", bus_if.o_a_ack, bus_if.o_b_ack);
        end
        n_vec++;
        step();
        bus_if.i_wb_ack = 0; bus_if.i_a_cyc = 0;
        @(negedge i_clk);
        if (bus_if.o_wb_cyc !== 1'b0) begin
            n_bad++; $display("FAIL read_drop_cyc: cyc %b expected 0", bus_if.o_wb_cyc);
        end
        n_vec++;
        step();
        if (dut.state !== ARB_IDLE || dut.pend !== 5'd0) begin
            n_bad++; $display("FAIL read_end_idle: state %0d pend %0d, expected IDLE and 0", dut.state, dut.pend);
        end
        n_vec++;
    endtask

    task automatic test_both_request();
        bus_if.i_a_cyc = 1; bus_if.i_a_addr = 32'hA0;
        bus_if.i_b_cyc = 1; bus_if.i_b_addr = 32'hB0;
        step();
        @(negedge i_clk);
        if (dut.state !== ARB_OWN_A || bus_if.o_wb_addr !== 32'hA0 || bus_if.o_b_stall !== 1'b1) begin
            n_bad++; $display("FAIL both_prio_a: state %0d addr %h b_stall %b, expected OWN_A a0 1",
                              dut.state, bus_if.o_wb_addr, bus_if.o_b_stall);
        end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge i_clk);
            if (bus_if.o_b_stall !== 1'b1 || bus_if.o_b_ack !== 1'b0) begin
                n_bad++; $display("FAIL both_b_held: cycle %0d b_stall %b b_ack %b, expected 1 0", i, bus_if.o_b_stall, bus_if.o_b_ack);
            end
            n_vec++;
        end
        step();
        bus_if.i_a_cyc = 0;
        @(negedge i_clk);
        if (bus_if.o_wb_cyc !== 1'b0 || bus_if.o_b_stall !== 1'b1) begin
            n_bad++; $display("FAIL both_a_drop: cyc %b b_stall %b, expected 0 1", bus_if.o_wb_cyc, bus_if.o_b_stall);
        end
        n_vec++;
        step();
        if (dut.state !== ARB_IDLE) begin
            n_bad++; $display("FAIL both_idle_gap: state %0d expected IDLE", dut.state);
        end
        n_vec++;
        step();
        @(negedge i_clk);
        if (bus_if.o_wb_cyc !== 1'b1 || bus_if.o_wb_addr !== 32'hB0 || bus_if.o_b_stall !== 1'b0) begin
            n_bad++; $display("FAIL both_b_granted: cyc %b addr %h b_stall %b, expected 1 b0 0",
                              bus_if.o_wb_cyc, bus_if.o_wb_addr, bus_if.o_b_stall);
        end
        n_vec++;
        bus_if.i_b_cyc = 0;
        step(); step();
    endtask

    task automatic test_burst_stall();
        logic [31:0] a;
        bus_if.i_a_cyc = 1; bus_if.i_a_stb = 1; bus_if.i_a_we = 1; bus_if.i_a_addr = 32'h200;
        bus_if.i_a_data = $urandom;
        step();
        for (int k = 0; k < 4; k++) begin
            a = 32'h200 + 32'(4 * k);
            bus_if.i_a_addr = a; bus_if.i_a_data = $urandom;
            if (k == 1) begin
                bus_if.i_wb_stall = 1;
                @(negedge i_clk);
                if (bus_if.o_wb_addr !== a || bus_if.o_a_stall !== 1'b1 || bus_if.o_wb_we !== 1'b1) begin
                    n_bad++; $display("FAIL burst_stalled: addr %h a_stall %b we %b, expected %h 1 1",
                                      bus_if.o_wb_addr, bus_if.o_a_stall, bus_if.o_wb_we, a);
                end
                n_vec++;
                step();
                bus_if.i_wb_stall = 0;
                @(negedge i_clk);
                if (bus_if.o_wb_addr !== a || dut.pend !== 5'd1) begin
                    n_bad++; $display("FAIL burst_addr_held: addr %h pend %0d, expected %h 1", bus_if.o_wb_addr, dut.pend, a);
                end
                n_vec++;
            end
            step();
        end
        bus_if.i_a_stb = 0;
        if (dut.pend !== 5'd4) begin
            n_bad++; $display("FAIL burst_pend_peak: pend %0d expected 4", dut.pend);
        end
        n_vec++;
        for (int k = 0; k < 4; k++) begin
            bus_if.i_wb_ack = 1;
            @(negedge i_clk);
            if (bus_if.o_a_ack !== 1'b1) begin
                n_bad++; $display("FAIL burst_ack: ack %0d a_ack %b expected 1", k, bus_if.o_a_ack);
            end
            n_vec++;
            step();
            if (dut.pend !== 5'(3 - k)) begin
                n_bad++; $display("FAIL burst_pend_drain: pend %0d expected %0d", dut.pend, 3 - k);
            end
            n_vec++;
        end
        bus_if.i_wb_ack = 0; bus_if.i_a_cyc = 0; bus_if.i_a_we = 0;
        step(); step();
    endtask

    task automatic test_err();
        bus_if.i_b_cyc = 1; bus_if.i_b_stb = 1; bus_if.i_b_addr = 32'h300;
        step(); step();
        bus_if.i_b_stb = 0;
        if (dut.pend !== 5'd1 || dut.state !== ARB_OWN_B) begin
            n_bad++; $display("FAIL err_setup: pend %0d state %0d, expected 1 OWN_B", dut.pend, dut.state);
        end
        n_vec++;
        bus_if.i_wb_err = 1;
        @(negedge i_clk);
        if (bus_if.o_b_err !== 1'b1 || bus_if.o_a_err !== 1'b0 || bus_if.o_b_ack !== 1'b0) begin
            n_bad++; $display("FAIL err_route: b_err %b a_err %b b_ack %b, expected 1 0 0", bus_if.o_b_err, bus_if.o_a_err, bus_if.o_b_ack);
        end
        n_vec++;
        step();
        if (dut.pend !== 5'd0) begin
            n_bad++; $display("FAIL err_pend_clear: pend %0d expected 0", dut.pend);
        end
        n_vec++;
        bus_if.i_wb_err = 0; bus_if.i_b_cyc = 0;
        @(negedge i_clk);
        if (bus_if.o_b_err !== 1'b0) begin
            n_bad++; $display("FAIL err_one_clock: b_err %b expected 0", bus_if.o_b_err);
        end
        n_vec++;
        step();
        if (dut.state !== ARB_IDLE) begin
            n_bad++; $display("FAIL err_to_idle: state %0d expected IDLE", dut.state);
        end
        n_vec++;
    endtask

    task automatic test_reset_midburst();
        logic [72:0] exp_o;
        exp_o = '0; exp_o[4] = 1'b1; exp_o[1] = 1'b1;
        bus_if.i_a_cyc = 1; bus_if.i_a_stb = 1; bus_if.i_a_addr = 32'h500;
        step(); step(); step();
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        if (dut_outputs() !== exp_o) begin
            n_bad++; $display("FAIL midreset_outputs: got %h expected %h", dut_outputs(), exp_o);
        end
        n_vec++;
        if (dut.state !== ARB_IDLE || dut.pend !== 5'd0) begin
            n_bad++; $display("FAIL midreset_state: state %0d pend %0d, expected IDLE and 0", dut.state, dut.pend);
        end
        n_vec++;
        model_reset();
        idle_inputs();
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_timeout();
        bus_if.i_a_cyc = 1; bus_if.i_a_stb = 1; bus_if.i_a_addr = 32'h400;
        step(); step();
        bus_if.i_a_stb = 0;
`ifdef WBARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            @(negedge i_clk);
            if (bus_if.o_a_err !== (k == TMO) || bus_if.o_wb_cyc !== (k != TMO)) begin
                n_bad++; $display("FAIL timeout_clock: clock %0d a_err %b cyc %b, expected %b %b",
                                  k, bus_if.o_a_err, bus_if.o_wb_cyc, k == TMO, k != TMO);
            end
            n_vec++;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            if (bus_if.o_wb_cyc !== 1'b0 || bus_if.o_a_err !== 1'b0 || dut.state !== ARB_IDLE || dut.pend !== 5'd0) begin
                n_bad++; $display("FAIL timeout_lockout: cyc %b a_err %b state %0d pend %0d, expected 0 0 IDLE 0",
                                  bus_if.o_wb_cyc, bus_if.o_a_err, dut.state, dut.pend);
            end
            n_vec++;
            step();
        end
`else
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (bus_if.o_a_err !== 1'b0 || bus_if.o_wb_cyc !== 1'b1 || dut.pend !== 5'd1) begin
                n_bad++; $display("FAIL no_timeout_hang: clock %0d a_err %b cyc %b pend %0d, expected 0 1 1",
                                  k, bus_if.o_a_err, bus_if.o_wb_cyc, dut.pend);
            end
            n_vec++;
            step();
        end
`endif
        bus_if.i_a_cyc = 0;
        step(); step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if (bus_if.i_a_cyc) bus_if.i_a_cyc = ($urandom_range(0, 7) != 0);
            else bus_if.i_a_cyc = ($urandom_range(0, 3) == 0);
            if (bus_if.i_b_cyc) bus_if.i_b_cyc = ($urandom_range(0, 7) != 0);
            else bus_if.i_b_cyc = ($urandom_range(0, 3) == 0);
            bus_if.i_a_stb    = bus_if.i_a_cyc & ($urandom_range(0, 1) == 1);
            bus_if.i_b_stb    = bus_if.i_b_cyc & ($urandom_range(0, 1) == 1);
            bus_if.i_a_we     = $urandom_range(0, 1) == 1;
            bus_if.i_b_we     = $urandom_range(0, 1) == 1;
            bus_if.i_a_addr   = $urandom;
            bus_if.i_b_addr   = $urandom;
            bus_if.i_a_data   = $urandom;
            bus_if.i_b_data   = $urandom;
            bus_if.i_wb_ack   = $urandom_range(0, 2) == 0;
            bus_if.i_wb_stall = $urandom_range(0, 3) == 0;
            bus_if.i_wb_err   = $urandom_range(0, 39) == 0;
            @(negedge i_clk);
            if (dut_outputs() !== m_outputs()) begin
                n_bad++; $display("FAIL random_outputs: cycle %0d got %h expected %h", c, dut_outputs(), m_outputs());
            end
            n_vec++;
            if (dut.pend !== 5'(m_pend)) begin
                n_bad++; $display("FAIL random_pend: cycle %0d pend %0d expected %0d", c, dut.pend, m_pend);
            end
            n_vec++;
            step();
        end
        idle_inputs();
        step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_both_request();
        test_burst_stall();
        test_err();
        test_reset_midburst();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
